// File: rtl/periph_bus_ctrl_if.sv
// Bundles the CPU command/response channels and the peripheral select/ack bus
// of periph_bus_ctrl; master is the controller side, slave the environment side.
interface periph_bus_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int DEV_W   = 5,
  parameter int NUM_DEV = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [DEV_W-1:0]          cmd_device;
  logic                      cmd_write;
  logic [DATA_W-1:0]         cmd_wdata;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;

  logic [NUM_DEV-1:0]        dev_sel;
  logic                      dev_wr;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV*DATA_W-1:0] dev_rdata;
  logic [NUM_DEV-1:0]        dev_ack;

  modport master (
    input  cmd_valid, cmd_device, cmd_write, cmd_wdata,
    input  rsp_ready,
    input  dev_rdata, dev_ack,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output dev_sel, dev_wr, dev_wdata
  );

  modport slave (
    output cmd_valid, cmd_device, cmd_write, cmd_wdata,
    output rsp_ready,
    output dev_rdata, dev_ack,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  dev_sel, dev_wr, dev_wdata
  );
endinterface

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus master: one CPU command at a time, one-hot select/ack
// handshake to NUM_DEV devices, bounded ack wait with error response.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | cmd_ready high, waiting for a CPU command
//   S_SELECT | first select cycle, ack ignored, ack timer loaded
//   S_XFER   | select held, waiting for ack from the selected device
//   S_RESP   | response presented until the CPU takes it
module periph_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEV_W   = 5,
  parameter int NUM_DEV = 8,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  periph_bus_ctrl_if.master bus
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_XFER   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic               cmd_fire;
  logic               bad_idx;
  logic               ack_sel;
  logic               tmr_tc;
  logic [NUM_DEV-1:0] sel_onehot;
  logic [DATA_W-1:0]  sel_rdata;

  assign cmd_fire  = bus.cmd_valid && (state == S_IDLE);
  assign bad_idx   = (32'(bus.cmd_device) >= NUM_DEV);
  assign ack_sel   = bus.dev_ack[idx_q];
  assign sel_rdata = bus.dev_rdata[int'(idx_q)*DATA_W +: DATA_W];
  // Timer counts down from TIMEOUT-1 loaded in S_SELECT; zero marks the last S_XFER cycle.
  assign tmr_tc    = (tmr_q == '0);

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nxt = bad_idx ? S_RESP : S_SELECT;
        end
      end
      S_SELECT: state_nxt = S_XFER;
      S_XFER: begin
        if (ack_sel || tmr_tc) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.dev_sel   = '0;
    bus.dev_wr    = 1'b0;
    bus.dev_wdata = '0;
    case (state)
      S_IDLE: bus.cmd_ready = 1'b1;
      S_SELECT, S_XFER: begin
        bus.dev_sel   = sel_onehot;
        bus.dev_wr    = wr_q;
        bus.dev_wdata = wdata_q;
      end
      S_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      tmr_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            idx_q   <= bus.cmd_device[IDX_W-1:0];
            wr_q    <= bus.cmd_write;
            wdata_q <= bus.cmd_wdata;
            if (bad_idx) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        S_SELECT: tmr_q <= TMR_LOAD;
        S_XFER: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (ack_sel) begin
            rdata_q <= wr_q ? '0 : sel_rdata;
            err_q   <= 1'b0;
          end else if (tmr_tc) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Scoreboard bench for periph_bus_ctrl: randomized and directed commands,
// a peripheral responder, and a response monitor checking against a model.
module tb_periph_bus_ctrl;
  localparam int DATA_W  = 32;
  localparam int DEV_W   = 5;
  localparam int NUM_DEV = 8;
  localparam int TIMEOUT = 255;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  int          plan_dev = NUM_DEV;
  bit          plan_wr = 1'b0;
  logic [31:0] plan_wdata = '0;
  int          plan_delay = -1;
  bit          plan_sel_pulse = 1'b0;
  logic [7:0]  plan_stray = '0;
  int          ready_mode = 0;

  periph_bus_ctrl_if #(.DATA_W(DATA_W), .DEV_W(DEV_W), .NUM_DEV(NUM_DEV)) bus ();

  periph_bus_ctrl #(
    .DATA_W(DATA_W), .DEV_W(DEV_W), .NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // Reference: bad index answers at once; an ack on XFER cycle d+1 (d < TIMEOUT)
  // answers 2+d edges after accept; otherwise the TIMEOUT-th XFER cycle errors.
  function automatic exp_t model(input int dev, input bit wr, input logic [31:0] rd,
                                 input int delay, input int acc);
    exp_t e;
    e.acc = acc;
    if (dev >= NUM_DEV) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 0;
    end else if (delay >= 0 && delay < TIMEOUT) begin
      e.rdata = wr ? 32'd0 : rd; e.err = 1'b0; e.lat = delay + 2;
    end else begin
      e.rdata = '0; e.err = 1'b1; e.lat = TIMEOUT + 1;
    end
    return e;
  endfunction

  // Peripheral side: acks only from the planned device, optional stray acks.
  int c = 0;
  bit prev_active = 1'b0;
  always @(posedge clk) begin
    logic [7:0] ack;
    logic [7:0] own;
    bit         act;
    #1;
    own = (plan_dev < NUM_DEV) ? (8'd1 << plan_dev) : 8'd0;
    act = (bus.dev_sel != '0);
    if (act) c = prev_active ? c + 1 : 0;
    prev_active = act;
    ack = '0;
    if (act) begin
      chk("dev_sel", bus.dev_sel, own);
      chk("dev_wr", bus.dev_wr, plan_wr);
      chk("dev_wdata", bus.dev_wdata, plan_wdata);
      if (c == 0) begin
        if (plan_sel_pulse) ack = own;
      end else if (plan_delay >= 0 && c - 1 >= plan_delay) begin
        ack = own;
      end
      ack = ack | (plan_stray & ~own);
    end
    bus.dev_ack = ack;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
      default: bus.rsp_ready = 1'b0;
    endcase
  end

  // Response monitor: compares every presented cycle against the queue head.
  bit          first_seen = 1'b0;
  bit          have_last = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      have_last  = 1'b0;
      first_seen = 1'b0;
    end else if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = exp_q[0];
        if (!first_seen) begin
          chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          first_seen = 1'b1;
        end
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", bus.rsp_err, e.err);
        chk("dev_sel_in_resp", bus.dev_sel, 64'd0);
        chk("cmd_ready_in_resp", bus.cmd_ready, 64'd0);
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          first_seen = 1'b0;
          have_last  = 1'b1;
          last_rdata = e.rdata;
          last_err   = e.err;
        end
      end
    end else if (have_last) begin
      chk("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
      chk("rsp_err_hold", bus.rsp_err, last_err);
    end
  end

  task automatic issue(input int dev, input bit wr, input logic [31:0] wdata,
                       input logic [31:0] rd, input int delay, input bit sel_pulse,
                       input logic [7:0] stray, input bit expect_rsp);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        n_fail++;
        $display("FAIL cmd_ready_wait: got 0 expected 1 within 2000 cycles");
        finish_test();
        return;
      end
    end
    for (int i = 0; i < NUM_DEV; i++) bus.dev_rdata[i*DATA_W +: DATA_W] = $urandom;
    if (dev < NUM_DEV) bus.dev_rdata[dev*DATA_W +: DATA_W] = rd;
    plan_dev       = dev;
    plan_wr        = wr;
    plan_wdata     = wdata;
    plan_delay     = delay;
    plan_sel_pulse = sel_pulse;
    plan_stray     = stray;
    bus.cmd_device = DEV_W'(dev);
    bus.cmd_write  = wr;
    bus.cmd_wdata  = wdata;
    bus.cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_device = DEV_W'($urandom);
    bus.cmd_write  = 1'($urandom);
    bus.cmd_wdata  = $urandom;
    if (expect_rsp) exp_q.push_back(model(dev, wr, rd, delay, cyc));
  endtask

  initial begin
    int n;
    int dly;
    int r;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_device = '0;
    bus.cmd_write  = 1'b0;
    bus.cmd_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus.dev_rdata  = '0;
    bus.dev_ack    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 64'd1);
    chk("reset_rsp_valid", bus.rsp_valid, 64'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("reset_rsp_err", bus.rsp_err, 64'd0);
    chk("reset_dev_sel", bus.dev_sel, 64'd0);
    chk("reset_dev_wr", bus.dev_wr, 64'd0);
    chk("reset_dev_wdata", bus.dev_wdata, 64'd0);

    ready_mode = 0;
    issue(3, 1'b1, 32'hDEADBEEF, $urandom, 0, 1'b0, 8'h00, 1'b1);
    issue(7, 1'b0, $urandom, 32'h12345678, 5, 1'b0, 8'h00, 1'b1);
    issue(2, 1'b0, $urandom, $urandom, -1, 1'b0, 8'h00, 1'b1);
    issue(9, 1'b0, $urandom, $urandom, 0, 1'b0, 8'h00, 1'b1);
    issue(6, 1'b0, $urandom, $urandom, TIMEOUT - 1, 1'b0, 8'h00, 1'b1);
    issue(1, 1'b1, $urandom, $urandom, TIMEOUT, 1'b0, 8'h00, 1'b1);
    issue(0, 1'b0, $urandom, $urandom, 3, 1'b1, 8'h00, 1'b1);
    issue(5, 1'b0, $urandom, $urandom, 4, 1'b0, 8'hFF, 1'b1);
    issue(31, 1'b1, $urandom, $urandom, 0, 1'b0, 8'h00, 1'b1);

    ready_mode = 2;
    issue(5, 1'b0, $urandom, $urandom, 2, 1'b0, 8'h00, 1'b1);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_seen", bus.rsp_valid, 64'd1);
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid  = (i == 4);
      bus.cmd_device = 5'd1;
      @(negedge clk);
      chk("stall_cmd_ready", bus.cmd_ready, 64'd0);
    end
    bus.cmd_valid = 1'b0;
    ready_mode = 0;

    issue(4, 1'b0, $urandom, $urandom, -1, 1'b0, 8'h02, 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_dev_sel", bus.dev_sel, 64'd0);
    chk("abort_rsp_valid", bus.rsp_valid, 64'd0);
    chk("abort_cmd_ready", bus.cmd_ready, 64'd1);
    plan_stray = '0;

    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      dly = -1;
      else if (r == 1) dly = TIMEOUT - 1;
      else             dly = $urandom_range(0, 10);
      issue($urandom_range(0, 11), 1'($urandom), $urandom, $urandom, dly,
            1'($urandom), ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00, 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    finish_test();
  end
endmodule
